// File: rtl/alt_vipvfr131_common_avalon_mm_master_if.sv
// Command, response, Avalon-MM and interrupt signals of the VIP control master.
// The master modport is the control-master side; the slave modport is the
// environment side (sequencer plus control slave).
interface alt_vipvfr131_common_avalon_mm_master_if #(
    parameter int unsigned AV_ADDRESS_WIDTH = 5,
    parameter int unsigned AV_DATA_WIDTH    = 16
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [AV_ADDRESS_WIDTH-1:0] cmd_address;
    logic [AV_DATA_WIDTH-1:0]    cmd_writedata;

    logic                        rsp_valid;
    logic                        rsp_write;
    logic [AV_DATA_WIDTH-1:0]    rsp_readdata;

    logic [AV_ADDRESS_WIDTH-1:0] av_address;
    logic                        av_read;
    logic                        av_write;
    logic [AV_DATA_WIDTH-1:0]    av_writedata;
    logic [AV_DATA_WIDTH-1:0]    av_readdata;
    logic                        av_waitrequest;

    logic                        irq;
    logic                        irq_status_valid;
    logic [AV_DATA_WIDTH-1:0]    irq_status;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_readdata,
        output av_address, av_read, av_write, av_writedata,
        input  av_readdata, av_waitrequest,
        input  irq,
        output irq_status_valid, irq_status
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_readdata,
        input  av_address, av_read, av_write, av_writedata,
        output av_readdata, av_waitrequest,
        output irq,
        input  irq_status_valid, irq_status
    );
endinterface

// File: rtl/alt_vipvfr131_common_avalon_mm_master.sv
// Avalon-MM control master: turns single commands into single-word Avalon
// read/write transfers and services the slave interrupt line by reading the
// interrupt register and writing the same value back to clear it.
module alt_vipvfr131_common_avalon_mm_master #(
    parameter int unsigned AV_ADDRESS_WIDTH = 5,
    parameter int unsigned AV_DATA_WIDTH    = 16,
    parameter int unsigned READ_LATENCY     = 1,
    parameter int unsigned IRQ_ENABLE       = 1,
    parameter int unsigned IRQ_ADDRESS      = 2
) (
    input  logic clk_i,
    input  logic rst_i,   // asynchronous, active low
    alt_vipvfr131_common_avalon_mm_master_if.master bus
);

    localparam int unsigned CW = $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);
    localparam logic [AV_ADDRESS_WIDTH-1:0] IRQ_ADDR = AV_ADDRESS_WIDTH'(IRQ_ADDRESS);

    typedef enum logic [2:0] {
        IDLE,
        CMD_WR,
        CMD_RD,
        RD_WAIT,
        IRQ_RD,
        IRQ_WAIT,
        IRQ_CLR
    } state_t;

    state_t                      state_q, state_d;
    logic [AV_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [AV_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [AV_DATA_WIDTH-1:0]    cap_q, cap_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic                        rsp_write_q, rsp_write_d;
    logic [AV_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                        irqv_q, irqv_d;
    logic [AV_DATA_WIDTH-1:0]    irqs_q, irqs_d;

    logic irq_req;

    assign irq_req = (IRQ_ENABLE != 0) && bus.irq;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            irqv_q      <= 1'b0;
            irqs_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            irqv_q      <= irqv_d;
            irqs_q      <= irqs_d;
        end
    end

    // Next-state logic: command acceptance, transfer completion, read-latency
    // counting and interrupt service sequencing.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        irqv_d      = 1'b0;
        irqs_d      = irqs_q;

        unique case (state_q)
            IDLE: begin
                // Interrupt service wins over a pending command.
                if (irq_req) begin
                    state_d = IRQ_RD;
                end else if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_address;
                    wdata_d = bus.cmd_writedata;
                    state_d = bus.cmd_write ? CMD_WR : CMD_RD;
                end
            end
            CMD_WR: begin
                if (!bus.av_waitrequest) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            CMD_RD: begin
                if (!bus.av_waitrequest) begin
                    state_d = RD_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RD_WAIT: begin
                if (cnt_q == LAT) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bus.av_readdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IRQ_RD: begin
                if (!bus.av_waitrequest) begin
                    state_d = IRQ_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            IRQ_WAIT: begin
                if (cnt_q == LAT) begin
                    cnt_d = '0;
                    cap_d = bus.av_readdata;
                    if (bus.av_readdata != '0) begin
                        state_d = IRQ_CLR;
                    end else begin
                        // Spurious interrupt: nothing to clear, report zero.
                        state_d = IDLE;
                        irqv_d  = 1'b1;
                        irqs_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IRQ_CLR: begin
                if (!bus.av_waitrequest) begin
                    state_d = IDLE;
                    irqv_d  = 1'b1;
                    irqs_d  = cap_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus-facing outputs decoded from state; address/data are zero without a strobe.
    always_comb begin
        bus.cmd_ready    = (state_q == IDLE) && !irq_req;
        bus.av_read      = 1'b0;
        bus.av_write     = 1'b0;
        bus.av_address   = '0;
        bus.av_writedata = '0;

        unique case (state_q)
            CMD_WR: begin
                bus.av_write     = 1'b1;
                bus.av_address   = addr_q;
                bus.av_writedata = wdata_q;
            end
            CMD_RD: begin
                bus.av_read    = 1'b1;
                bus.av_address = addr_q;
            end
            IRQ_RD: begin
                bus.av_read    = 1'b1;
                bus.av_address = IRQ_ADDR;
            end
            IRQ_CLR: begin
                bus.av_write     = 1'b1;
                bus.av_address   = IRQ_ADDR;
                bus.av_writedata = cap_q;
            end
            default: begin
            end
        endcase

        bus.rsp_valid        = rsp_valid_q;
        bus.rsp_write        = rsp_write_q;
        bus.rsp_readdata     = rsp_rdata_q;
        bus.irq_status_valid = irqv_q;
        bus.irq_status       = irqs_q;
    end

endmodule
